// File: rtl/spi_cfg_master_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_cfg_master_if
// Brief    : Two-port write-request channel into the SPI config controller.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_cfg_master_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [6:0] req0_addr;
    logic [7:0] req0_data;
    logic       req1_valid;
    logic       req1_ready;
    logic [6:0] req1_addr;
    logic [7:0] req1_data;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready
    );
endinterface
`default_nettype wire

// File: rtl/spi_cfg_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_cfg_master
// Brief    : Round-robin arbiter + serializer of 16-bit SPI write frames
//            (1, addr[6:0], data[7:0]) MSB first, slow registered SCLK.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cfg_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    spi_cfg_master_if.slave  req_if,
    output logic             sclk,
    output logic             copi,
    output logic             ncs,
    output logic             busy,
    output logic             done,
    output logic             done_id
);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_setup    = 3'd1;
    localparam logic [2:0] c_st_shift_hi = 3'd2;
    localparam logic [2:0] c_st_shift_lo = 3'd3;
    localparam logic [2:0] c_st_gap      = 3'd4;

    localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);
    localparam logic [7:0] c_gap_last = 8'(GAP_CYCLES - 1);

    logic [2:0]  r_state,  w_state;
    logic [7:0]  r_cnt,    w_cnt;
    logic [15:0] r_shift,  w_shift;
    logic [3:0]  r_bitcnt, w_bitcnt;
    logic        r_final,  w_final;
    logic        r_last_grant, w_last_grant;
    logic        r_grant_id,   w_grant_id;
    logic        r_sclk,   w_sclk;
    logic        r_copi,   w_copi;
    logic        r_ncs,    w_ncs;
    logic        r_done,   w_done;
    logic        r_done_id, w_done_id;
    logic        w_ready0, w_ready1;
    logic        w_can_accept;
    logic        w_phase_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_cnt        <= 8'd0;
            r_shift      <= 16'd0;
            r_bitcnt     <= 4'd0;
            r_final      <= 1'b0;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_sclk       <= 1'b0;
            r_copi       <= 1'b0;
            r_ncs        <= 1'b1;
            r_done       <= 1'b0;
            r_done_id    <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_shift      <= w_shift;
            r_bitcnt     <= w_bitcnt;
            r_final      <= w_final;
            r_last_grant <= w_last_grant;
            r_grant_id   <= w_grant_id;
            r_sclk       <= w_sclk;
            r_copi       <= w_copi;
            r_ncs        <= w_ncs;
            r_done       <= w_done;
            r_done_id    <= w_done_id;
        end
    end

    // Pin values are computed for the state being entered, so every pin is
    // a flop output and changes exactly on the phase boundary.
    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt + 8'd1;
        w_shift      = r_shift;
        w_bitcnt     = r_bitcnt;
        w_final      = r_final;
        w_last_grant = r_last_grant;
        w_grant_id   = r_grant_id;
        w_sclk       = r_sclk;
        w_copi       = r_copi;
        w_ncs        = r_ncs;
        w_done       = 1'b0;
        w_done_id    = r_done_id;
        w_ready0     = 1'b0;
        w_ready1     = 1'b0;
        w_can_accept = (r_state == c_st_idle) && !rst;
        w_phase_end  = (r_cnt == c_div_last);

        case (r_state)
            c_st_idle: begin
                w_cnt    = 8'd0;
                w_ready0 = w_can_accept && req_if.req0_valid &&
                           (!req_if.req1_valid || r_last_grant);
                w_ready1 = w_can_accept && req_if.req1_valid &&
                           (!req_if.req0_valid || !r_last_grant);
                if (w_ready0) begin
                    w_shift      = {1'b1, req_if.req0_addr, req_if.req0_data};
                    w_last_grant = 1'b0;
                    w_grant_id   = 1'b0;
                end else if (w_ready1) begin
                    w_shift      = {1'b1, req_if.req1_addr, req_if.req1_data};
                    w_last_grant = 1'b1;
                    w_grant_id   = 1'b1;
                end
                if (w_ready0 || w_ready1) begin
                    w_bitcnt = 4'd15;
                    w_final  = 1'b0;
                    w_state  = c_st_setup;
                    w_ncs    = 1'b0;
                    w_sclk   = 1'b0;
                    w_copi   = w_shift[15];
                end
            end
            c_st_setup: begin
                if (w_phase_end) begin
                    w_cnt   = 8'd0;
                    w_state = c_st_shift_hi;
                    w_sclk  = 1'b1;
                end
            end
            c_st_shift_hi: begin
                if (w_phase_end) begin
                    w_cnt   = 8'd0;
                    w_state = c_st_shift_lo;
                    w_sclk  = 1'b0;
                    if (r_bitcnt != 4'd0) begin
                        w_shift  = r_shift << 1;
                        w_bitcnt = r_bitcnt - 4'd1;
                        w_copi   = r_shift[14];
                    end else begin
                        w_final  = 1'b1;
                    end
                end
            end
            c_st_shift_lo: begin
                if (w_phase_end) begin
                    w_cnt = 8'd0;
                    if (r_final) begin
                        w_state   = c_st_gap;
                        w_ncs     = 1'b1;
                        w_copi    = 1'b0;
                        w_done    = 1'b1;
                        w_done_id = r_grant_id;
                    end else begin
                        w_state = c_st_shift_hi;
                        w_sclk  = 1'b1;
                    end
                end
            end
            c_st_gap: begin
                if (r_cnt == c_gap_last) begin
                    w_cnt   = 8'd0;
                    w_state = c_st_idle;
                end
            end
            default: begin
                w_cnt   = 8'd0;
                w_state = c_st_idle;
            end
        endcase
    end

    assign req_if.req0_ready = w_ready0;
    assign req_if.req1_ready = w_ready1;
    assign sclk    = r_sclk;
    assign copi    = r_copi;
    assign ncs     = r_ncs;
    assign busy    = (r_state != c_st_idle);
    assign done    = r_done;
    assign done_id = r_done_id;

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cfg_master
// Brief    : Directed bench for spi_cfg_master with a small SPI peripheral model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cfg_master;

    localparam int c_div    = 4;
    localparam int c_gap    = 4;
    localparam int c_low    = 33 * c_div;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk, copi, ncs, busy, done, done_id;

    int total = 0;
    int bad   = 0;

    spi_cfg_master_if bus();

    spi_cfg_master #(.CLK_DIV(c_div), .GAP_CYCLES(c_gap)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_if  (bus.slave),
        .sclk    (sclk),
        .copi    (copi),
        .ncs     (ncs),
        .busy    (busy),
        .done    (done),
        .done_id (done_id)
    );

    always #5 clk = ~clk;

    // Peripheral model and link monitor, evaluated mid-cycle on negedge.
    logic [7:0]  en_reg_out_7_0 = 8'h00;
    logic [7:0]  en_reg_pwm_7_0 = 8'h00;
    logic [7:0]  pwm_duty_cycle = 8'h00;
    logic        prev_sclk = 1'b0, prev_copi = 1'b0, prev_ncs = 1'b1;
    int          rise_cnt = 0, low_cnt = 0, high_run = 0;
    int          gap_last = 0, gap_prev = 0;
    int          last_low = 0, last_rise = 0;
    int          frame_count = 0, done_count = 0, bad_frames = 0;
    int          copi_viol = 0, rdy_viol = 0, ready1_cycles = 0;
    logic [15:0] bits = 16'h0;
    logic        done_ids[$];
    logic [15:0] frame_bits[$];

    always @(negedge clk) begin
        if (rst) begin
            rise_cnt = 0; low_cnt = 0; bits = 16'h0; high_run = 0;
            en_reg_out_7_0 = 8'h00; en_reg_pwm_7_0 = 8'h00; pwm_duty_cycle = 8'h00;
        end else begin
            if (!ncs && prev_ncs) begin
                rise_cnt = 0; low_cnt = 0; bits = 16'h0;
                gap_prev = gap_last; gap_last = high_run;
            end
            if (!ncs) low_cnt++;
            if (sclk && !prev_sclk) begin
                rise_cnt++;
                bits = {bits[14:0], copi};
            end
            if (sclk && prev_sclk && (copi !== prev_copi)) copi_viol++;
            if (ncs && !prev_ncs) begin
                last_low = low_cnt; last_rise = rise_cnt;
                frame_bits.push_back(bits);
                frame_count++;
                if (rise_cnt != 16 || low_cnt != c_low) bad_frames++;
                if (rise_cnt == 16 && bits[15]) begin
                    case (bits[14:8])
                        7'd0: en_reg_out_7_0 = bits[7:0];
                        7'd2: en_reg_pwm_7_0 = bits[7:0];
                        7'd4: pwm_duty_cycle = bits[7:0];
                        default: ;
                    endcase
                end
                high_run = 0;
            end
            if (ncs) high_run++;
            if (done) begin
                done_count++;
                done_ids.push_back(done_id);
            end
            if (bus.req1_ready) ready1_cycles++;
            if ((bus.req0_ready || bus.req1_ready) && busy) rdy_viol++;
        end
        prev_sclk = sclk; prev_copi = copi; prev_ncs = ncs;
    end

    task automatic wait_frames(input int target, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk); #1;
            if (frame_count >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk); #1;
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_addr = 7'd2; bus.req0_data = 8'h0F;
        bus.req1_valid = 1'b1; bus.req1_addr = 7'd4; bus.req1_data = 8'h80;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total += 7;
            if (ncs !== 1'b1)  begin bad++; $display("FAIL reset_ncs got=%b want=1", ncs); end
            if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b want=0", sclk); end
            if (copi !== 1'b0) begin bad++; $display("FAIL reset_copi got=%b want=0", copi); end
            if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
            if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
            if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL reset_rdy0 got=%b want=0", bus.req0_ready); end
            if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL reset_rdy1 got=%b want=0", bus.req1_ready); end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total += 2;
        if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL first_grant_rdy0 got=%b want=1", bus.req0_ready); end
        if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL first_grant_rdy1 got=%b want=0", bus.req1_ready); end
    endtask

    task automatic test_contention();
        logic [15:0] exp_bits [4];
        int  fbase, dbase;
        bit  ok;
        exp_bits = '{16'h820F, 16'h8480, 16'h820F, 16'h8480};
        fbase = frame_bits.size();
        dbase = done_ids.size();
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk); #1;
            if (done_count >= dbase + 4) begin ok = 1'b1; break; end
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL contention_timeout done_count=%0d want=%0d", done_count, dbase + 4); end
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL contention_idle busy=%b want=0", busy); end
        for (int i = 0; i < 4; i++) begin
            logic exp_id;
            exp_id = (i % 2 == 1);
            total += 2;
            if (frame_bits[fbase + i] !== exp_bits[i]) begin
                bad++; $display("FAIL contention_frame%0d got=%h want=%h", i, frame_bits[fbase + i], exp_bits[i]);
            end
            if (done_ids[dbase + i] !== exp_id) begin
                bad++; $display("FAIL contention_done_id%0d got=%b want=%b", i, done_ids[dbase + i], exp_id);
            end
        end
        total += 3;
        if (en_reg_pwm_7_0 !== 8'h0F) begin bad++; $display("FAIL contention_pwm got=%h want=0f", en_reg_pwm_7_0); end
        if (pwm_duty_cycle !== 8'h80) begin bad++; $display("FAIL contention_duty got=%h want=80", pwm_duty_cycle); end
        if (done_count !== dbase + 4) begin bad++; $display("FAIL contention_done_count got=%0d want=%0d", done_count, dbase + 4); end
    endtask

    task automatic test_single_write();
        int  fbase, dbase;
        bit  ok;
        fbase = frame_count;
        dbase = done_count;
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_addr = 7'h00; bus.req0_data = 8'hA5;
        @(negedge clk);
        total++;
        if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL single_rdy0 got=%b want=1", bus.req0_ready); end
        @(posedge clk); #1;
        // Changes after the accept cycle must not leak into the frame.
        bus.req0_valid = 1'b0; bus.req0_data = 8'h00; bus.req0_addr = 7'h7F;
        wait_frames(fbase + 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_timeout frames=%0d want=%0d", frame_count, fbase + 1); end
        wait_idle(ok);
        total += 7;
        if (last_low !== c_low) begin bad++; $display("FAIL single_ncs_low got=%0d want=%0d", last_low, c_low); end
        if (last_rise !== 16) begin bad++; $display("FAIL single_rises got=%0d want=16", last_rise); end
        if (frame_bits[fbase] !== 16'h80A5) begin bad++; $display("FAIL single_bits got=%h want=80a5", frame_bits[fbase]); end
        if (done_count !== dbase + 1) begin bad++; $display("FAIL single_done_count got=%0d want=%0d", done_count, dbase + 1); end
        if (done_ids[dbase] !== 1'b0) begin bad++; $display("FAIL single_done_id got=%b want=0", done_ids[dbase]); end
        if (en_reg_out_7_0 !== 8'hA5) begin bad++; $display("FAIL single_reg_out got=%h want=a5", en_reg_out_7_0); end
        if (copi_viol !== 0) begin bad++; $display("FAIL single_copi_stable violations=%0d want=0", copi_viol); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] datas [3];
        int  fbase, rbase;
        bit  ok;
        datas = '{8'h11, 8'h22, 8'h33};
        fbase = frame_count;
        rbase = ready1_cycles;
        @(posedge clk); #1;
        bus.req1_valid = 1'b1; bus.req1_addr = 7'd4; bus.req1_data = datas[0];
        for (int k = 0; k < 3; k++) begin
            bit found;
            found = 1'b0;
            for (int c = 0; c < 400 && !found; c++) begin
                @(negedge clk);
                if (bus.req1_ready) found = 1'b1;
            end
            total++;
            if (!found) begin bad++; $display("FAIL b2b_ready%0d timeout got=0 want=1", k); end
            @(posedge clk); #1;
            if (k < 2) bus.req1_data = datas[k + 1];
            else       bus.req1_valid = 1'b0;
        end
        wait_frames(fbase + 3, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_timeout frames=%0d want=%0d", frame_count, fbase + 3); end
        wait_idle(ok);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (frame_bits[fbase + k] !== {8'h84, datas[k]}) begin
                bad++; $display("FAIL b2b_frame%0d got=%h want=%h", k, frame_bits[fbase + k], {8'h84, datas[k]});
            end
        end
        total += 5;
        if (gap_prev !== c_gap + 1) begin bad++; $display("FAIL b2b_gap1 got=%0d want=%0d", gap_prev, c_gap + 1); end
        if (gap_last !== c_gap + 1) begin bad++; $display("FAIL b2b_gap2 got=%0d want=%0d", gap_last, c_gap + 1); end
        if (ready1_cycles - rbase !== 3) begin bad++; $display("FAIL b2b_ready_cycles got=%0d want=3", ready1_cycles - rbase); end
        if (rdy_viol !== 0) begin bad++; $display("FAIL b2b_ready_while_busy got=%0d want=0", rdy_viol); end
        if (pwm_duty_cycle !== 8'h33) begin bad++; $display("FAIL b2b_duty got=%h want=33", pwm_duty_cycle); end
    endtask

    task automatic test_reset_mid_frame();
        int  fbase, dbase;
        bit  found, ok;
        fbase = frame_count;
        dbase = done_count;
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_addr = 7'd0; bus.req0_data = 8'h3C;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk); #1;
            if (rise_cnt == 5) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL midrst_5th_edge timeout rises=%0d want=5", rise_cnt); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total += 4;
        if (ncs !== 1'b1)  begin bad++; $display("FAIL midrst_ncs got=%b want=1", ncs); end
        if (sclk !== 1'b0) begin bad++; $display("FAIL midrst_sclk got=%b want=0", sclk); end
        if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        total += 2;
        if (done_count !== dbase) begin bad++; $display("FAIL midrst_no_done got=%0d want=%0d", done_count, dbase); end
        if (frame_count !== fbase) begin bad++; $display("FAIL midrst_no_frame got=%0d want=%0d", frame_count, fbase); end
        @(posedge clk); #1;
        bus.req1_valid = 1'b1; bus.req1_addr = 7'd2; bus.req1_data = 8'h5A;
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        wait_frames(fbase + 1, ok);
        wait_idle(ok);
        total += 4;
        if (last_rise !== 16) begin bad++; $display("FAIL midrst_new_rises got=%0d want=16", last_rise); end
        if (frame_bits[frame_bits.size() - 1] !== 16'h825A) begin
            bad++; $display("FAIL midrst_new_bits got=%h want=825a", frame_bits[frame_bits.size() - 1]);
        end
        if (en_reg_pwm_7_0 !== 8'h5A) begin bad++; $display("FAIL midrst_pwm got=%h want=5a", en_reg_pwm_7_0); end
        if (done_count !== dbase + 1) begin bad++; $display("FAIL midrst_new_done got=%0d want=%0d", done_count, dbase + 1); end
    endtask

    task automatic test_out_of_range();
        int  fbase, dbase;
        bit  ok;
        fbase = frame_count;
        dbase = done_count;
        @(posedge clk); #1;
        bus.req1_valid = 1'b1; bus.req1_addr = 7'h05; bus.req1_data = 8'hFF;
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        wait_frames(fbase + 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL oor_timeout frames=%0d want=%0d", frame_count, fbase + 1); end
        wait_idle(ok);
        total += 8;
        if (frame_bits[fbase] !== 16'h85FF) begin bad++; $display("FAIL oor_bits got=%h want=85ff", frame_bits[fbase]); end
        if (last_rise !== 16) begin bad++; $display("FAIL oor_rises got=%0d want=16", last_rise); end
        if (done_count !== dbase + 1) begin bad++; $display("FAIL oor_done got=%0d want=%0d", done_count, dbase + 1); end
        if (done_ids[done_ids.size() - 1] !== 1'b1) begin bad++; $display("FAIL oor_done_id got=%b want=1", done_ids[done_ids.size() - 1]); end
        if (en_reg_out_7_0 !== 8'h00) begin bad++; $display("FAIL oor_reg_out got=%h want=00", en_reg_out_7_0); end
        if (en_reg_pwm_7_0 !== 8'h5A) begin bad++; $display("FAIL oor_reg_pwm got=%h want=5a", en_reg_pwm_7_0); end
        if (pwm_duty_cycle !== 8'h00) begin bad++; $display("FAIL oor_reg_duty got=%h want=00", pwm_duty_cycle); end
        if (bad_frames !== 0 || copi_viol !== 0) begin
            bad++; $display("FAIL frame_shape bad_frames=%0d copi_viol=%0d want=0", bad_frames, copi_viol);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req0_valid = 1'b0; bus.req0_addr = 7'd0; bus.req0_data = 8'd0;
        bus.req1_valid = 1'b0; bus.req1_addr = 7'd0; bus.req1_data = 8'd0;
        test_reset();
        test_contention();
        test_single_write();
        test_back_to_back();
        test_reset_mid_frame();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_cfg_master.md
Name: spi_cfg_master

Overview:
- Controller that writes the chip's SPI configuration register file. Two internal requesters (port 0, port 1) share one SPI link to the SPI register peripheral, arbitrated round-robin.
- Each accepted request is serialized as one 16-bit write frame, MSB first: bit15 = 1 (write), bits14:8 = address, bits7:0 = data.
- SCLK is slow relative to clk, so the peripheral's 2-FF synchronizers sample every edge.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period and per SETUP phase; legal range 3..255; 8-bit phase counter.
GAP_CYCLES, 4, clk cycles ncs is held high after each frame before returning to IDLE; legal range 1..255.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
req0_valid  input  1  port 0 request valid
req0_ready  output  1  port 0 accept (combinational)
req0_addr  input  7  port 0 register address
req0_data  input  8  port 0 write data
req1_valid  input  1  port 1 request valid
req1_ready  output  1  port 1 accept (combinational)
req1_addr  input  7  port 1 register address
req1_data  input  8  port 1 write data
sclk  output  1  SPI clock, idle low, registered
copi  output  1  SPI data, registered
ncs  output  1  SPI chip select, active-low, registered
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at end of each frame
done_id  output  1  port served by the frame signalled by done

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, ncs=1, sclk=0, copi=0, done=0, done_id=0, last_grant=1 (port 0 wins first contention).
- Reset mid-frame: takes effect at the next clk edge. The frame is abandoned with no done pulse. The peripheral's bit counter is then misaligned, so the system must reset it as well.
- States: IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP.
- IDLE:
  - req0_ready = req0_valid && (!req1_valid || last_grant==1).
  - req1_ready = req1_valid && (!req0_valid || last_grant==0).
  - Both readies are forced to 0 outside IDLE.
  - On valid&&ready: latch shift = {1'b1, addr, data}, set last_grant and grant_id to the port served, bitcnt=15, go to SETUP.
- SETUP: ncs=0, sclk=0, copi=shift[15]. Lasts CLK_DIV cycles, then SHIFT_HI.
- SHIFT_HI: sclk=1, copi unchanged. Lasts CLK_DIV cycles.
  - If bitcnt!=0: go to SHIFT_LO, shift left, decrement bitcnt.
  - If bitcnt==0: go to SHIFT_LO in final mode.
- SHIFT_LO: sclk=0. copi takes the new shift[15] on entry and stays stable for the whole phase. Lasts CLK_DIV cycles.
  - Normal mode: go to SHIFT_HI.
  - Final mode: copi holds bit0; go to GAP.
- GAP: ncs=1, sclk=0, copi=0. done=1 with done_id=grant_id on the first GAP cycle only. Lasts GAP_CYCLES cycles, then IDLE.
- Frame timing:
  - ncs low for exactly 33*CLK_DIV cycles; exactly 16 SCLK rising edges per frame.
  - copi never changes while sclk=1.
  - Minimum ncs-high gap between back-to-back frames: GAP_CYCLES+1 cycles (GAP plus one IDLE accept cycle).
- Address handling: addresses are not range-checked. Any 7-bit address is transmitted unchanged and done still pulses.
- Request inputs are sampled only in the accept cycle; later changes do not affect the frame in flight.

Test Plan:
- Reset: hold rst 3 cycles with both valids high -> ncs=1, sclk=0, copi=0, busy=0, done=0, both readies 0 during rst. First accept after release goes to port 0.
- Single write, CLK_DIV=4: port0 addr=0x00 data=0xA5 -> ncs low 132 cycles, 16 sclk rising edges, copi bits 1,0000000,10100101. done=1 with done_id=0 for one cycle. Bench peripheral en_reg_out_7_0=0xA5.
- Contention: both valid from reset (p0 addr 2 data 0x0F, p1 addr 4 data 0x80) -> p0 frame first, then p1. With both held valid, the grants continue alternating 0,1,0,1 and each done_id matches. Peripheral ends with en_reg_pwm_7_0=0x0F and pwm_duty_cycle=0x80.
- Back-to-back single port: req1_valid held high for 3 requests -> 3 frames; ncs high for exactly GAP_CYCLES+1=5 cycles between frames; req1_ready high only in the IDLE cycles.
- Reset mid-frame: assert rst after the 5th sclk rising edge -> next cycle ncs=1, sclk=0, busy=0, no done pulse. A new request afterwards produces a full 16-edge frame.
- Out-of-range address: port1 addr=0x05 data=0xFF -> full frame transmitted, done pulses, all peripheral registers unchanged.
